data_mem_port_ctrl: RTL and testbench
=====================================

// Module: data_mem_port_ctrl
// PURPOSE
//  Initiator side of the data-memory port: the CPU load/store path issues single-byte
//  read/write requests here, and this block sequences them onto the memory's
//  address/data_in/write_en/data_out interface (combinational read, write on posedge).
//  It returns each result on a valid/ready response channel. One request is in flight at a time.
// PARAMETERS
//  ADDR_W   4    memory address width; DEPTH = 2**ADDR_W locations
//  DATA_W   8    memory word width
// PORTS
//  clk           in   1       system clock, all state on posedge
//  rst           in   1       asynchronous, active-high reset
//  req_valid     in   1       request present
//  req_ready     out  1       request accepted when req_valid & req_ready at posedge
//  req_write     in   1       1 = store, 0 = load
//  req_addr      in   ADDR_W  target address
//  req_wdata     in   DATA_W  store data
//  rsp_valid     out  1       response present
//  rsp_ready     in   1       response consumed when rsp_valid & rsp_ready at posedge
//  rsp_rdata     out  DATA_W  load data; for stores, echo of stored byte
//  mem_address   out  ADDR_W  to memory address
//  mem_data_in   out  DATA_W  to memory data_in
//  mem_write_en  out  1       to memory write_en
//  mem_data_out  in   DATA_W  from memory data_out (combinational read)
//  busy          out  1       high in any state other than IDLE
// BEHAVIOUR
//  - States: IDLE, ACCESS, RESP (+CLEAR with macro). Reset -> IDLE.
//  - Reset values: rsp_valid 0, rsp_rdata 0, mem_address 0, mem_data_in 0, mem_write_en 0, busy 0.
//  - req_ready = (state==IDLE) & ~rst. Requests are never accepted in ACCESS/RESP/CLEAR.
//  - Accept edge: latch req_addr/req_wdata/req_write into registers; go to ACCESS.
//  - ACCESS (exactly 1 cycle): mem_address = latched addr, mem_data_in = latched data.
//    mem_write_en = 1 only in ACCESS of a store. Load: capture mem_data_out into
//    rsp_rdata at the end of ACCESS. Store: rsp_rdata <= latched wdata. Next state RESP.
//  - RESP: rsp_valid = 1. rsp_valid and rsp_rdata stay stable until handshake. On handshake
//    go to IDLE, clear rsp_valid.
//  - Latency: rsp_valid rises 2 posedges after accept. Max throughput: 1 request / 3 cycles.
//  - mem_write_en is never high outside ACCESS-of-store or CLEAR. It is glitch-free (decoded from registers).
//  - mem_address/mem_data_in hold their last value in IDLE/RESP.
//  - Address is not range-checked: all 2**ADDR_W values are legal.
//  - Reset mid-operation: all outputs go to reset values immediately and the FSM goes to IDLE.
//    An in-flight store whose ACCESS edge has not occurred is dropped. No response is issued.
// CONFIGURATION
//  DATA_MEM_CLEAR_EN defined:
//    - Adds ports clr_start (in, 1) and clr_done (out, 1, reset 0).
//    - clr_start high in IDLE -> CLEAR. clr_start beats req_valid in the same cycle; req_ready is 0.
//    - CLEAR: counter 0..DEPTH-1; mem_address = counter, mem_data_in = 0, mem_write_en = 1;
//      one location per cycle (DEPTH cycles).
//    - After the last write: clr_done pulses for 1 cycle, FSM returns to IDLE.
//    - clr_start outside IDLE is ignored.
//  DATA_MEM_CLEAR_EN undefined: no clr_* ports, no CLEAR state. Behaviour is otherwise identical.
// TESTING (bench instantiates the data memory, 16x8, contents after power-up 07,03,02,01,06,04,05,08,07,00..)
//  1. Load addr 0 after reset -> rsp_valid 2 cycles after accept, rsp_rdata=8'h07; addr 7 -> 8'h08.
//  2. Store 8'hA5 @ addr 9, then load addr 9 -> store rsp echo 8'hA5; mem_write_en high exactly
//     1 cycle; load returns 8'hA5; other locations unchanged.
//  3. rsp_ready low 5 cycles -> rsp_valid=1 and rsp_rdata stable; req_ready=0, busy=1 throughout.
//  4. rsp_ready tied high, 4 back-to-back loads with req_valid held -> one accept every 3 cycles,
//     responses in order.
//  5. Assert rst during RESP of a load -> rsp_valid=0 immediately; after release req_ready=1,
//     no stale response.
//  6. (CLEAR_EN) clr_start with req_valid in same cycle -> 16 write cycles, addr 0..15, clr_done
//     one pulse, all bytes 0, then the pending request is accepted.

Source files
------------

// File: rtl/data_mem_port_ctrl.sv
// data_mem_port_ctrl: initiator side of the data-memory port, one byte request in flight at a time
//   Sequences CPU load/store requests onto a combinational-read / posedge-write memory
//   and returns each result on a valid/ready response channel.
//   Optional feature macro: DATA_MEM_CLEAR_EN (adds clr_start/clr_done and a memory clear sweep).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake; req_write, req_addr, req_wdata payload
//   rsp_valid/rsp_ready              response handshake; rsp_rdata load data or store echo
//   mem_address/mem_data_in/mem_write_en/mem_data_out   memory interface
//   clr_start/clr_done               clear request and one-cycle completion pulse (macro only)
//   busy                             high whenever not IDLE
module data_mem_port_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
`ifdef DATA_MEM_CLEAR_EN
    input  logic              clr_start,
    output logic              clr_done,
`endif
    output logic              busy
);
`ifdef DATA_MEM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic write_q, write_d;
`ifdef DATA_MEM_CLEAR_EN
    logic clr_done_q, clr_done_d;
`endif
    // The memory-side registers double as the request latch, so they naturally hold in IDLE/RESP.
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        rsp_rdata_d   = rsp_rdata_q;
        write_d       = write_q;
`ifdef DATA_MEM_CLEAR_EN
        clr_done_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef DATA_MEM_CLEAR_EN
                if (clr_start) begin
                    state_d       = CLEAR;
                    mem_address_d = '0;
                    mem_data_in_d = '0;
                end else
`endif
                if (req_valid) begin
                    state_d       = ACCESS;
                    mem_address_d = req_addr;
                    mem_data_in_d = req_wdata;
                    write_d       = req_write;
                end
            end
            ACCESS: begin
                rsp_rdata_d = write_q ? mem_data_in_q : mem_data_out;
                state_d     = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
`ifdef DATA_MEM_CLEAR_EN
            CLEAR: begin
                // Sweep one location per cycle; stop on the last address and hold it.
                mem_address_d = &mem_address_q ? mem_address_q : mem_address_q + ADDR_ONE;
                state_d       = &mem_address_q ? IDLE : CLEAR;
                clr_done_d    = &mem_address_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            rsp_rdata_q   <= '0;
            write_q       <= 1'b0;
`ifdef DATA_MEM_CLEAR_EN
            clr_done_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_rdata_q   <= rsp_rdata_d;
            write_q       <= write_d;
`ifdef DATA_MEM_CLEAR_EN
            clr_done_q    <= clr_done_d;
`endif
        end
    end
    assign rsp_valid   = state_q == RESP;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = state_q != IDLE;
`ifdef DATA_MEM_CLEAR_EN
    assign clr_done     = clr_done_q;
    assign req_ready    = (state_q == IDLE) & ~rst & ~clr_start;
    assign mem_write_en = (state_q == ACCESS && write_q) || state_q == CLEAR;
`else
    assign req_ready    = (state_q == IDLE) & ~rst;
    assign mem_write_en = state_q == ACCESS && write_q;
`endif
endmodule

// File: tb/tb_data_mem_port_ctrl.sv
// tb_data_mem_port_ctrl: randomized self-checking bench with a scoreboard memory model
module tb_data_mem_port_ctrl;
    localparam int AW = 4, DW = 8, DEPTH = 16;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic mem_write_en, busy;
`ifdef DATA_MEM_CLEAR_EN
    logic clr_start = 1'b0, clr_done;
`endif
    always #5 clk = ~clk;
    data_mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
`ifdef DATA_MEM_CLEAR_EN
        .clr_start(clr_start), .clr_done(clr_done),
`endif
        .busy(busy)
    );
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    assign mem_data_out = mem[mem_address];
    always @(posedge clk) if (mem_write_en) mem[mem_address] <= mem_data_in;
    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Scoreboard: expected response per accepted request, accept times for latency/throughput.
    int cyc = 0, we_cnt = 0, last_acc = -1;
    bit b2b = 1'b0, prev_rv = 1'b0;
    logic [DW-1:0] exp_q[$];
    int acc_q[$];
    always @(negedge clk) begin
        cyc++;
        if (mem_write_en) we_cnt++;
        if (!rst && req_valid && req_ready) begin
            if (b2b && last_acc >= 0) check("throughput", cyc - last_acc, 3);
            last_acc = cyc;
            acc_q.push_back(cyc);
            if (req_write) begin
                ref_mem[req_addr] = req_wdata;
                exp_q.push_back(req_wdata);
            end else exp_q.push_back(ref_mem[req_addr]);
        end
        if (!rst && rsp_valid && !prev_rv) begin
            if (acc_q.size() == 0) check("rsp_without_req", 1, 0);
            else check("latency", cyc - acc_q.pop_front(), 2);
        end
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("spurious_rsp", 1, 0);
            else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
        end
        prev_rv = rsp_valid;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("accept_timeout", 0, 1);
    endtask
    task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        int we0;
        logic [DW-1:0] first;
        we0 = we_cnt;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
        wait_ready();
        tick();
        req_valid = 1'b0;
        check("access_busy", busy, 1);
        check("access_addr", mem_address, a);
        check("access_we", mem_write_en, w);
        if (w) check("access_wdata", mem_data_in, d);
        check("access_rv", rsp_valid, 0);
        tick();
        check("resp_rv", rsp_valid, 1);
        first = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            check("hold_rv", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, first);
            check("hold_ready", req_ready, 0);
            check("hold_busy", busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("done_rv", rsp_valid, 0);
        check("done_busy", busy, 0);
        check("we_cycles", we_cnt - we0, {31'd0, w});
    endtask
    initial begin
        logic [DW-1:0] init_v [10];
        logic [DW-1:0] old;
        init_v = '{8'h07, 8'h03, 8'h02, 8'h01, 8'h06, 8'h04, 8'h05, 8'h08, 8'h07, 8'h00};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (i < 10) ? init_v[i] : 8'h00;
            ref_mem[i] = mem[i];
        end
        #1;
        check("rst_rv", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", mem_address, 0);
        check("rst_din", mem_data_in, 0);
        check("rst_we", mem_write_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready, 1);
        do_txn(1'b0, 4'd0, 8'h00, 0);
        do_txn(1'b0, 4'd7, 8'h00, 0);
        do_txn(1'b1, 4'd9, 8'hA5, 0);
        do_txn(1'b0, 4'd9, 8'h00, 0);
        do_txn(1'b0, 4'd1, 8'h00, 5);
        // Back-to-back loads with the response side always ready.
        rsp_ready = 1'b1; b2b = 1'b1; last_acc = -1;
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = AW'(i * 3 + 1);
            wait_ready();
            tick();
        end
        req_valid = 1'b0;
        repeat (4) tick();
        b2b = 1'b0; rsp_ready = 1'b0;
        check("b2b_drained", exp_q.size(), 0);
        // Reset while a load response is pending.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
        wait_ready();
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_rv", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_rv", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rdata", rsp_rdata, 0);
        check("midrst_ready", req_ready, 0);
        exp_q.delete(); acc_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("rel_ready", req_ready, 1);
        rsp_ready = 1'b1;
        repeat (3) tick();
        check("no_stale_rv", rsp_valid, 0);
        rsp_ready = 1'b0;
        // Reset during the ACCESS cycle of a store: the write must be dropped.
        old = ref_mem[5];
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 8'h3C;
        wait_ready();
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("drop_we", mem_write_en, 0);
        ref_mem[5] = old;
        exp_q.delete(); acc_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("drop_mem", mem[5], old);
`ifdef DATA_MEM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd2;
        #1;
        check("clr_ready", req_ready, 0);
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            check("clr_addr", mem_address, k);
            check("clr_we", mem_write_en, 1);
            check("clr_din", mem_data_in, 0);
            check("clr_done_early", clr_done, 0);
            tick();
        end
        check("clr_done", clr_done, 1);
        tick();
        req_valid = 1'b0;
        check("clr_done_pulse", clr_done, 0);
        rsp_ready = 1'b1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        check("clr_req_served", exp_q.size(), 0);
`endif
        for (int t = 0; t < 40; t++)
            do_txn(1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)), DW'($urandom), int'($urandom_range(3)));
        check("queue_empty", exp_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) check("mem_final", mem[i], ref_mem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end
endmodule
